pkt_gen_ctrl_axil_slave: RTL

PKT_GEN_CTRL_AXIL_SLAVE -- requirements
Module: pkt_gen_ctrl_axil_slave

---
 rtl/pkt_gen_ctrl_axil_slave.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pkt_gen_ctrl_axil_slave.sv
// pkt_gen_ctrl_axil_slave: AXI4-Lite register slave holding packet generator config and status
module pkt_gen_ctrl_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_ctrl,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_pkt_len,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_pkt_cnt,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_ipg,
  output logic                            start_pulse,
  input  logic                            status_busy,
  input  logic [15:0]                     status_sent_cnt
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t r_wstate, w_wnext;
  r_state_t r_rstate, w_rnext;
  logic r_en;
  logic [AW-1:0] r_awaddr;
  logic [DW-1:0] r_wdata;
  logic [DW/8-1:0] r_wstrb;
  logic [3:0][DW-1:0] r_regs;
  logic [DW-1:0] r_rdata;
  logic [1:0] r_bresp, r_rresp;
  logic r_start;
  logic w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata, w_rval;
  logic [DW/8-1:0] w_wstrb;
  logic [2:0] w_widx, w_ridx;
  logic w_unused;
  // ready outputs held low through reset and for the edge it releases on
  assign s00_axi_awready = r_en && (r_wstate == W_IDLE || r_wstate == W_GOT_W);
  assign s00_axi_wready  = r_en && (r_wstate == W_IDLE || r_wstate == W_GOT_AW);
  assign s00_axi_arready = r_en && r_rstate == R_IDLE;
  assign s00_axi_bvalid  = r_wstate == W_RESP;
  assign s00_axi_bresp   = r_bresp;
  assign s00_axi_rvalid  = r_rstate == R_DATA;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = r_rresp;
  assign cfg_ctrl        = r_regs[0];
  assign cfg_pkt_len     = r_regs[1];
  assign cfg_pkt_cnt     = r_regs[2];
  assign cfg_ipg         = r_regs[3];
  assign start_pulse     = r_start;
  assign w_aw_hs  = s00_axi_awvalid && s00_axi_awready;
  assign w_w_hs   = s00_axi_wvalid && s00_axi_wready;
  assign w_ar_hs  = s00_axi_arvalid && s00_axi_arready;
  assign w_commit = (w_aw_hs || r_wstate == W_GOT_AW) && (w_w_hs || r_wstate == W_GOT_W);
  assign w_waddr  = r_wstate == W_GOT_AW ? r_awaddr : s00_axi_awaddr;
  assign w_wdata  = r_wstate == W_GOT_W ? r_wdata : s00_axi_wdata;
  assign w_wstrb  = r_wstate == W_GOT_W ? r_wstrb : s00_axi_wstrb;
  assign w_widx   = w_waddr[4:2];
  assign w_ridx   = s00_axi_araddr[4:2];
  assign w_rval   = !w_ridx[2] ? r_regs[w_ridx[1:0]] :
                    w_ridx == 3'd4 ? {status_sent_cnt, 15'b0, status_busy} : '0;
  assign w_unused = &{1'b0, s00_axi_awprot, s00_axi_arprot, w_waddr[1:0], s00_axi_araddr[1:0]};
  always_comb begin
    w_wnext = w_commit ? W_RESP :
              w_aw_hs ? W_GOT_AW :
              w_w_hs ? W_GOT_W :
              (r_wstate == W_RESP && s00_axi_bready) ? W_IDLE : r_wstate;
    w_rnext = w_ar_hs ? R_DATA : (r_rstate == R_DATA && s00_axi_rready) ? R_IDLE : r_rstate;
  end
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_reset) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
      r_en     <= 1'b0;
    end else begin
      r_wstate <= w_wnext;
      r_rstate <= w_rnext;
      r_en     <= 1'b1;
    end
  end
  always_ff @(posedge s00_axi_aclk) begin
    if (w_aw_hs) r_awaddr <= s00_axi_awaddr;
    if (w_w_hs) begin
      r_wdata <= s00_axi_wdata;
      r_wstrb <= s00_axi_wstrb;
    end
  end
  // reads sample the register array before this edge's write lands
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_reset) begin
      r_regs  <= '0;
      r_rdata <= '0;
      r_rresp <= 2'b00;
      r_bresp <= 2'b00;
      r_start <= 1'b0;
    end else begin
      r_start <= w_commit && w_widx == 3'd0 && w_wstrb[0] && w_wdata[0];
      if (w_commit) begin
        r_bresp <= w_widx > 3'd4 ? 2'b10 : 2'b00;
        if (!w_widx[2])
          for (int b = 0; b < DW / 8; b++)
            if (w_wstrb[b]) r_regs[w_widx[1:0]][8*b +: 8] <= w_wdata[8*b +: 8];
      end
      if (w_ar_hs) begin
        r_rdata <= w_rval;
        r_rresp <= w_ridx > 3'd4 ? 2'b10 : 2'b00;
      end
    end
  end
endmodule
